tdec_wrap_crc_chk: RTL and testbench
====================================

TDEC_WRAP_CRC_CHK -- requirements
Module: tdec_wrap_crc_chk

Interface
REQ-001 Parameter CRC_W, default 12, CRC width in bits (legal 6..24).
REQ-002 Parameter POLY, default 12'h80F, generator polynomial, implicit x^CRC_W term omitted.
REQ-003 Parameter DW, default 8, input word width in bits (legal 1..32).
REQ-004 Port clk  input  1  the block's single clock; all logic rising-edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port blk_start  input  1  one-cycle pulse that opens a new code block.
REQ-007 Port din_vld  input  1  din qualifier.
REQ-008 Port din  input  DW  data word; din[DW-1] is the first bit in time.
REQ-009 Port din_last  input  1  marks the final word of the block; valid with din_vld only.
REQ-010 Port din_nb  input  $clog2(DW+1)  valid bits in the last word, 1..DW, MSB-aligned; ignored unless din_last.
REQ-011 Port err_clr  input  1  synchronous clear of err_cnt.
REQ-012 Port busy  output  1  high while in RUN.
REQ-013 Port crc_done  output  1  one-cycle result strobe.
REQ-014 Port crc_pass  output  1  high when the final remainder equals zero; valid while crc_done is high and held until the next crc_done.
REQ-015 Port crc_val  output  CRC_W  final remainder; held until the next crc_done.
REQ-016 Port err_cnt  output  16  count of failed blocks.

Function
REQ-017 The CRC register shall be seeded with all-zero and shall be updated by the serial LFSR (shift left, feedback = msb XOR data bit, XOR POLY) unrolled over the accepted bits in one cycle.
REQ-018 The checked block shall include its appended CRC bits; pass means remainder == 0.
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 IDLE->RUN on blk_start; RUN->DONE on an accepted word with din_last; DONE->IDLE unconditionally after one cycle.
REQ-021 A word shall be accepted when din_vld=1 and either state==RUN or blk_start=1.
REQ-022 blk_start with din_vld in the same cycle shall seed the register to zero and fold din into it; with din_last also set, the state goes straight to DONE.
REQ-023 blk_start in RUN shall abort the current block without a crc_done and restart from a zero seed.
REQ-024 din_vld in IDLE or DONE without blk_start shall be ignored.
REQ-025 When din_last is set, only the top din_nb bits of din are processed; din_nb=0 or din_nb>DW shall be treated as DW.
REQ-026 crc_done, crc_pass and crc_val shall update in the DONE cycle, one clock after the last word is accepted.
REQ-027 busy shall be 0 in IDLE and DONE.
REQ-028 blk_start in DONE shall be honoured: the result is still reported, and the next state is RUN.
REQ-029 The update path shall be a single combinational level between registers, for 307.2 MHz at DW=8 and CRC_W<=24.

Reset
REQ-030 On rst_n low: state=IDLE, CRC register=0, crc_val=0, crc_pass=0, crc_done=0, busy=0, err_cnt=0.
REQ-031 Reset mid-block shall discard the block; no crc_done is produced after release.

Configuration
REQ-032 Macro TDEC_CRC_ERRCNT_EN defined: err_cnt increments by 1 on each crc_done with crc_pass=0.
REQ-033 With TDEC_CRC_ERRCNT_EN defined, err_cnt saturates at 16'hFFFF.
REQ-034 With TDEC_CRC_ERRCNT_EN defined, err_clr has priority over an increment in the same cycle.
REQ-035 Macro TDEC_CRC_ERRCNT_EN undefined: err_cnt is tied to 0 and err_clr is unused; all other behaviour is identical.

Verification (defaults CRC_W=12, POLY=12'h80F, DW=8)
REQ-036 blk_start+din_vld+din_last, din=8'h01, din_nb=8 -> next cycle crc_done=1, crc_val=12'h80F, crc_pass=0.
REQ-037 Words 8'h01, 8'h80, then 8'hF0 with din_last and din_nb=4 -> crc_val=0, crc_pass=1, crc_done exactly one cycle after the third word.
REQ-038 Block of 16 words 8'h00 with idle gaps between words -> crc_pass=1, and busy stays high throughout the gaps.
REQ-039 Start a block, send 2 words, then blk_start again and send the REQ-036 block -> exactly one crc_done, carrying the REQ-036 result.
REQ-040 Assert rst_n low after 3 words of a block, then release -> no crc_done, all outputs 0; a new block then passes normally.
REQ-041 TDEC_CRC_ERRCNT_EN defined: three REQ-036 blocks -> err_cnt=3; err_clr asserted together with a fourth failing crc_done -> err_cnt=0.

Source files
------------

// File: rtl/tdec_wrap_crc_chk.sv
// Block CRC checker: folds DW-bit words MSB-first through a CRC_W-bit LFSR and reports the remainder per block.
// Optional failed-block counter enabled by defining TDEC_CRC_ERRCNT_EN.
module tdec_wrap_crc_chk #(
    parameter int unsigned          CRC_W = 12,
    parameter logic [CRC_W-1:0]     POLY  = CRC_W'(12'h80F),
    parameter int unsigned          DW    = 8,
    localparam int unsigned         NB_W  = $clog2(DW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_start,
    input  logic             din_vld,
    input  logic [DW-1:0]    din,
    input  logic             din_last,
    input  logic [NB_W-1:0]  din_nb,
    input  logic             err_clr,
    output logic             busy,
    output logic             crc_done,
    output logic             crc_pass,
    output logic [CRC_W-1:0] crc_val,
    output logic [15:0]      err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [CRC_W-1:0]  crc_q, crc_d, crc_fold;
    logic [NB_W-1:0]   nb_eff;
    logic              accept;
    logic              fb;

    // Number of bits to fold this cycle; out-of-range din_nb means a full word.
    always_comb begin
        nb_eff = NB_W'(DW);
        if (din_last && (din_nb != '0) && (32'(din_nb) <= DW))
            nb_eff = din_nb;
    end

    // Serial LFSR unrolled over the accepted bits, seeded from zero on blk_start.
    always_comb begin
        fb       = 1'b0;
        crc_fold = blk_start ? '0 : crc_q;
        for (int k = 0; k < int'(DW); k++) begin
            if (k < int'(nb_eff)) begin
                fb       = crc_fold[CRC_W-1] ^ din[DW-1-k];
                crc_fold = {crc_fold[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
            end
        end
    end

    // Next-state and CRC register update.
    always_comb begin
        state_nx = state;
        crc_d    = crc_q;
        accept   = din_vld && ((state == RUN) || blk_start);

        if (accept)
            crc_d = crc_fold;
        else if (blk_start)
            crc_d = '0;

        if (blk_start)
            state_nx = (din_vld && din_last) ? DONE : RUN;
        else if ((state == RUN) && din_vld && din_last)
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            crc_q <= '0;
        end else begin
            state <= state_nx;
            crc_q <= crc_d;
        end
    end

    // Result registers load on the edge that enters DONE and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            crc_done <= 1'b0;
            crc_pass <= 1'b0;
            crc_val  <= '0;
        end else begin
            busy     <= (state_nx == RUN);
            crc_done <= (state_nx == DONE);
            if (state_nx == DONE) begin
                crc_val  <= crc_fold;
                crc_pass <= (crc_fold == '0);
            end
        end
    end

`ifdef TDEC_CRC_ERRCNT_EN
    // Saturating failed-block counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (crc_done && !crc_pass && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_tdec_wrap_crc_chk.sv
// Directed bench for tdec_wrap_crc_chk at default parameters (CRC_W=12, POLY=12'h80F, DW=8).
// Expected remainders are hand-computed constants.
module tb_tdec_wrap_crc_chk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blk_start = 1'b0;
    logic        din_vld = 1'b0;
    logic [7:0]  din = '0;
    logic        din_last = 1'b0;
    logic [3:0]  din_nb = '0;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        crc_done;
    logic        crc_pass;
    logic [11:0] crc_val;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base;
    int err_exp;

    tdec_wrap_crc_chk dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_start (blk_start),
        .din_vld   (din_vld),
        .din       (din),
        .din_last  (din_last),
        .din_nb    (din_nb),
        .err_clr   (err_clr),
        .busy      (busy),
        .crc_done  (crc_done),
        .crc_pass  (crc_pass),
        .crc_val   (crc_val),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (crc_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 ns after the edge with inputs cleared.
    task automatic cyc(input logic bs, input logic v, input logic l,
                       input logic [7:0] d, input logic [3:0] nb);
        blk_start = bs; din_vld = v; din_last = l; din = d; din_nb = nb;
        @(posedge clk); #1;
        blk_start = 1'b0; din_vld = 1'b0; din_last = 1'b0; din = '0; din_nb = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        // Reset values
        idle(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(crc_done), 0);
        check("rst_pass", 32'(crc_pass), 0);
        check("rst_val", 32'(crc_val), 0);
        check("rst_err", 32'(err_cnt), 0);
        rst_n = 1'b1;
        idle(1);

        // Single-word block 0x01 -> remainder equals POLY
        cyc(1, 1, 1, 8'h01, 4'd8);
        check("w1_done", 32'(crc_done), 1);
        check("w1_val", 32'(crc_val), 32'h80F);
        check("w1_pass", 32'(crc_pass), 0);
        check("w1_busy", 32'(busy), 0);
        idle(1);
        check("w1_done_off", 32'(crc_done), 0);
        check("w1_val_hold", 32'(crc_val), 32'h80F);

        // Three words with partial last word -> zero remainder
        cyc(1, 1, 0, 8'h01, 4'd0);
        check("w3_busy", 32'(busy), 1);
        check("w3_done0", 32'(crc_done), 0);
        cyc(0, 1, 0, 8'h80, 4'd0);
        check("w3_done1", 32'(crc_done), 0);
        cyc(0, 1, 1, 8'hF0, 4'd4);
        check("w3_done", 32'(crc_done), 1);
        check("w3_val", 32'(crc_val), 0);
        check("w3_pass", 32'(crc_pass), 1);
        idle(1);

        // Sixteen zero words with gaps; busy holds through the gaps
        done_base = done_cnt;
        cyc(1, 1, 0, 8'h00, 4'd0);
        for (int i = 1; i < 16; i++) begin
            idle(2);
            check($sformatf("gap_busy_%0d", i), 32'(busy), 1);
            cyc(0, 1, (i == 15), 8'h00, 4'd8);
        end
        check("z16_done", 32'(crc_done), 1);
        check("z16_pass", 32'(crc_pass), 1);
        check("z16_val", 32'(crc_val), 0);
        idle(2);
        check("z16_cnt", 32'(done_cnt - done_base), 1);

        // Abort by blk_start mid-block, then the single-word block
        done_base = done_cnt;
        cyc(1, 1, 0, 8'h01, 4'd0);
        cyc(0, 1, 0, 8'h80, 4'd0);
        cyc(1, 1, 1, 8'h01, 4'd8);
        check("abort_val", 32'(crc_val), 32'h80F);
        check("abort_pass", 32'(crc_pass), 0);
        idle(2);
        check("abort_cnt", 32'(done_cnt - done_base), 1);

        // din_nb=0 on the last word means a full word
        cyc(1, 1, 1, 8'h01, 4'd0);
        check("nb0_val", 32'(crc_val), 32'h80F);
        idle(1);

        // din_vld without blk_start in IDLE is ignored
        done_base = done_cnt;
        cyc(0, 1, 1, 8'hFF, 4'd8);
        idle(2);
        check("idle_vld_cnt", 32'(done_cnt - done_base), 0);
        check("idle_vld_busy", 32'(busy), 0);

        // blk_start during DONE: result reported and a new block opens
        cyc(1, 1, 1, 8'h01, 4'd8);
        check("dstart_done", 32'(crc_done), 1);
        cyc(1, 1, 0, 8'h01, 4'd0);
        check("dstart_busy", 32'(busy), 1);
        check("dstart_done_off", 32'(crc_done), 0);
        cyc(0, 1, 0, 8'h80, 4'd0);
        cyc(0, 1, 1, 8'hF0, 4'd4);
        check("dstart_val", 32'(crc_val), 0);
        check("dstart_pass", 32'(crc_pass), 1);
        idle(1);

        // Reset mid-block discards it
        cyc(1, 1, 1, 8'h01, 4'd8);
        idle(1);
        cyc(1, 1, 0, 8'h01, 4'd0);
        cyc(0, 1, 0, 8'h80, 4'd0);
        cyc(0, 1, 0, 8'h00, 4'd0);
        check("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_val", 32'(crc_val), 0);
        idle(2);
        rst_n = 1'b1;
        done_base = done_cnt;
        idle(4);
        check("mid_cnt", 32'(done_cnt - done_base), 0);
        check("mid_busy_after", 32'(busy), 0);
        check("mid_pass_after", 32'(crc_pass), 0);
        cyc(1, 1, 0, 8'h01, 4'd0);
        cyc(0, 1, 0, 8'h80, 4'd0);
        cyc(0, 1, 1, 8'hF0, 4'd4);
        check("mid_new_done", 32'(crc_done), 1);
        check("mid_new_pass", 32'(crc_pass), 1);
        idle(1);

        // Failed-block counter and clear priority
        do_reset();
        for (int b = 0; b < 3; b++) begin
            cyc(1, 1, 1, 8'h01, 4'd8);
            idle(1);
        end
`ifdef TDEC_CRC_ERRCNT_EN
        err_exp = 3;
`else
        err_exp = 0;
`endif
        check("err_three", 32'(err_cnt), 32'(err_exp));
        cyc(1, 1, 1, 8'h01, 4'd8);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        idle(1);
        check("err_clr", 32'(err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
